// File: rtl/accum_sampler_pkg.sv
// -----------------------------------------------------------------------------
// accum_sampler_pkg
// Shared types and constants for the accumulator window sampler slice.
//   state_t   : sampler FSM states (IDLE, PRIME, ACCUM)
//   SUM_W     : width of the window sum (10 bits)
//   WRAP_W    : width of the wrap counter (4 bits)
//   SUM_MAX   : saturation value for the window sum (1023)
//   WRAP_MAX  : saturation value for the wrap counter (15)
//   sat_sum() / sat_wraps() : saturating accumulate helpers
// -----------------------------------------------------------------------------
package accum_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam int SUM_W  = 10;
    localparam int WRAP_W = 4;

    localparam logic [SUM_W-1:0]  SUM_MAX  = 10'd1023;
    localparam logic [WRAP_W-1:0] WRAP_MAX = 4'd15;

    // Add an 8-bit increment to the window sum, clamping at SUM_MAX.
    // One extra bit of headroom catches the carry out of the sum.
    function automatic logic [SUM_W-1:0] sat_sum(
        input logic [SUM_W-1:0] acc,
        input logic [7:0]       inc
    );
        logic [SUM_W:0] w_total;
        w_total = {1'b0, acc} + {3'b000, inc};
        return w_total[SUM_W] ? SUM_MAX : w_total[SUM_W-1:0];
    endfunction

    // Count one wrap, holding at WRAP_MAX once reached.
    function automatic logic [WRAP_W-1:0] sat_wraps(
        input logic [WRAP_W-1:0] acc,
        input logic              wrap
    );
        return (acc == WRAP_MAX) ? WRAP_MAX : acc + {3'b000, wrap};
    endfunction

endpackage

// File: rtl/accum_delta.sv
// -----------------------------------------------------------------------------
// accum_delta
// Combinational modulo-256 difference between the current accumulator sample
// and the previous one.
//   i_cur   [7:0] : current accumulator sample
//   i_prev  [7:0] : previous accumulator sample
//   o_inc   [7:0] : (i_cur - i_prev) mod 256
//   o_wrap        : 1 when the accumulator wrapped past 255 (i_cur < i_prev)
// -----------------------------------------------------------------------------
module accum_delta (
    input  logic [7:0] i_cur,
    input  logic [7:0] i_prev,
    output logic [7:0] o_inc,
    output logic       o_wrap
);

    // 8-bit subtraction wraps naturally, which is exactly the modulo-256
    // increment of an 8-bit counter that rolled over.
    assign o_inc  = i_cur - i_prev;
    assign o_wrap = (i_cur < i_prev);

endmodule

// File: rtl/accum_window_sampler.sv
// -----------------------------------------------------------------------------
// accum_window_sampler
// Samples an 8-bit integrator/counter every clock, rebuilds the per-cycle
// increment modulo 256 and sums it over WINDOW samples. Wrap-arounds within
// the window are counted as well. One result per window is offered on a
// valid/ready handshake; a new window result overwrites an unaccepted one.
//
// Parameters
//   WINDOW       : samples per window, 2..255
// Ports
//   clock        : rising-edge clock
//   reset        : asynchronous, active-low reset
//   enable       : run sampling; low returns the block to IDLE
//   in_value     : [7:0] accumulator value from the integrator/counter
//   out_valid    : result pending
//   out_ready    : consumer accepts the pending result
//   out_sum      : [9:0] window sum of increments, saturates at 1023
//   out_wraps    : [3:0] wrap count in the window, saturates at 15
//   out_overrun  : sticky flag, set when a result is overwritten before it was
//                  accepted; exists only with WINDOW_SAMPLER_OVERRUN_EN defined
// -----------------------------------------------------------------------------
module accum_window_sampler
    import accum_sampler_pkg::*;
#(
    parameter int unsigned WINDOW = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [7:0]        in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [WRAP_W-1:0] out_wraps
`ifdef WINDOW_SAMPLER_OVERRUN_EN
    ,
    output logic              out_overrun
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

    state_t            r_state;
    state_t            w_next_state;

    logic [7:0]        r_prev;
    logic [SUM_W-1:0]  r_acc_sum;
    logic [WRAP_W-1:0] r_acc_wraps;
    logic [7:0]        r_count;

    logic              r_out_valid;
    logic [SUM_W-1:0]  r_out_sum;
    logic [WRAP_W-1:0] r_out_wraps;

    logic [7:0]        w_inc;
    logic              w_wrap;
    logic [SUM_W-1:0]  w_sum_next;
    logic [WRAP_W-1:0] w_wraps_next;
    logic              w_sample;
    logic              w_close;
    logic              w_xfer;

    accum_delta u_delta (
        .i_cur  (in_value),
        .i_prev (r_prev),
        .o_inc  (w_inc),
        .o_wrap (w_wrap)
    );

    assign w_sum_next   = sat_sum(r_acc_sum, w_inc);
    assign w_wraps_next = sat_wraps(r_acc_wraps, w_wrap);

    // -------------------------------------------------------------------------
    // FSM next state and per-cycle strobes
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_close      = 1'b0;
        w_xfer       = r_out_valid & out_ready;

        unique case (r_state)
            IDLE: begin
                if (enable) w_next_state = PRIME;
            end
            PRIME: begin
                w_next_state = enable ? ACCUM : IDLE;
            end
            ACCUM: begin
                if (!enable) begin
                    // Dropping enable wins over a would-be window close.
                    w_next_state = IDLE;
                end else begin
                    w_sample = 1'b1;
                    w_close  = (r_count == LAST_IDX);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // -------------------------------------------------------------------------
    // Window accumulators. prev runs continuously across window boundaries so
    // back-to-back windows lose no increment.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev      <= '0;
            r_acc_sum   <= '0;
            r_acc_wraps <= '0;
            r_count     <= '0;
        end else if (r_state == PRIME) begin
            r_prev      <= in_value;
            r_acc_sum   <= '0;
            r_acc_wraps <= '0;
            r_count     <= '0;
        end else if (w_sample) begin
            r_prev <= in_value;
            if (w_close) begin
                r_acc_sum   <= '0;
                r_acc_wraps <= '0;
                r_count     <= '0;
            end else begin
                r_acc_sum   <= w_sum_next;
                r_acc_wraps <= w_wraps_next;
                r_count     <= r_count + 8'd1;
            end
        end else if (r_state == ACCUM) begin
            // Leaving ACCUM: the partial window is discarded.
            r_acc_sum   <= '0;
            r_acc_wraps <= '0;
            r_count     <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Output register and handshake. A close loads the new result whether or
    // not the old one is being transferred on the same edge, so valid simply
    // stays high in both the same-edge-transfer and overrun cases.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_wraps <= '0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum_next;
            r_out_wraps <= w_wraps_next;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_wraps = r_out_wraps;

`ifdef WINDOW_SAMPLER_OVERRUN_EN
    logic r_overrun;

    // Sticky until reset: a result was overwritten before being accepted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                            r_overrun <= 1'b0;
        else if (w_close && r_out_valid && !out_ready) r_overrun <= 1'b1;
    end

    assign out_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_accum_window_sampler.sv
// -----------------------------------------------------------------------------
// tb_accum_window_sampler
// Directed bench for accum_window_sampler with WINDOW = 16. Inputs change 1 ns
// after a rising edge and outputs are read at that same point, so each read
// reflects the edge just taken. Expected values are hand-computed from the
// ramps fed in. Define WINDOW_SAMPLER_OVERRUN_EN to also cover out_overrun.
// -----------------------------------------------------------------------------
module tb_accum_window_sampler;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] in_value;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_sum;
    logic [3:0] out_wraps;
`ifdef WINDOW_SAMPLER_OVERRUN_EN
    logic       out_overrun;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] val;

    accum_window_sampler #(.WINDOW(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_wraps (out_wraps)
`ifdef WINDOW_SAMPLER_OVERRUN_EN
        ,
        .out_overrun (out_overrun)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Feed n samples, each delta above the previous one (modulo 256).
    task automatic feed(input int n, input int delta);
        for (int i = 0; i < n; i++) begin
            val      = val + 8'(delta);
            in_value = val;
            tick();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        in_value  = 8'd0;
        val       = 8'd0;
        tick();
        tick();

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum",   32'(out_sum),   32'd0);
        check("rst_wraps", 32'(out_wraps), 32'd0);
`ifdef WINDOW_SAMPLER_OVERRUN_EN
        check("rst_overrun", 32'(out_overrun), 32'd0);
`endif

        // Ramp +1 from 0, out_ready high
        reset     = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        tick();                 // IDLE -> PRIME
        tick();                 // PRIME captures prev = 0
        feed(15, 1);
        check("ramp1_latency_valid", 32'(out_valid), 32'd0);
        feed(1, 1);             // 16th sample closes window
        check("ramp1_w1_valid", 32'(out_valid), 32'd1);
        check("ramp1_w1_sum",   32'(out_sum),   32'd16);
        check("ramp1_w1_wraps", 32'(out_wraps), 32'd0);
        feed(1, 1);             // accepted on this edge
        check("ramp1_accept_valid", 32'(out_valid), 32'd0);
        feed(15, 1);
        check("ramp1_w2_valid", 32'(out_valid), 32'd1);
        check("ramp1_w2_sum",   32'(out_sum),   32'd16);

        // Hold while not ready, then transfer on the close edge
        out_ready = 1'b0;
        feed(15, 2);
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sum",   32'(out_sum),   32'd16);
        out_ready = 1'b1;
        feed(1, 2);             // transfer + close same edge
        check("xfer_close_valid", 32'(out_valid), 32'd1);
        check("xfer_close_sum",   32'(out_sum),   32'd32);
`ifdef WINDOW_SAMPLER_OVERRUN_EN
        check("xfer_close_no_overrun", 32'(out_overrun), 32'd0);
`endif
        feed(1, 2);             // the new result is accepted once
        check("xfer_close_no_dup", 32'(out_valid), 32'd0);

        // Overrun: not ready for three window closes
        out_ready = 1'b0;
        feed(15, 2);
        check("ovr_w1_valid", 32'(out_valid), 32'd1);
        check("ovr_w1_sum",   32'(out_sum),   32'd32);
        feed(8, 1);
        check("ovr_mid_hold_sum", 32'(out_sum), 32'd32);
        feed(8, 1);
        check("ovr_w2_sum", 32'(out_sum), 32'd16);
`ifdef WINDOW_SAMPLER_OVERRUN_EN
        check("ovr_flag", 32'(out_overrun), 32'd1);
`endif
        feed(16, 4);
        check("ovr_w3_valid", 32'(out_valid), 32'd1);
        check("ovr_w3_sum",   32'(out_sum),   32'd64);
        check("ovr_w3_wraps", 32'(out_wraps), 32'd0);
        out_ready = 1'b1;
        feed(1, 4);
        check("ovr_accept_valid", 32'(out_valid), 32'd0);

        // Drop enable at sample 10, restore with a +3 ramp from 250
        feed(9, 1);
        enable = 1'b0;
        feed(1, 1);             // ACCUM -> IDLE, partial window dropped
        tick();
        check("drop_no_result", 32'(out_valid), 32'd0);
        enable = 1'b1;
        tick();                 // IDLE -> PRIME
        val      = 8'd250;
        in_value = val;
        tick();                 // PRIME captures prev = 250
        feed(15, 3);
        check("ramp3_latency_valid", 32'(out_valid), 32'd0);
        feed(1, 3);             // 253,0,3,...,42: one wrap
        check("ramp3_valid", 32'(out_valid), 32'd1);
        check("ramp3_sum",   32'(out_sum),   32'd48);
        check("ramp3_wraps", 32'(out_wraps), 32'd1);

        // enable low on the edge that would close the window
        feed(15, 3);            // first edge also accepts the pending result
        enable = 1'b0;
        feed(1, 3);
        check("en_low_close_valid", 32'(out_valid), 32'd0);
        tick();

        // Saturation: increment 255 every cycle (counting down by one)
        enable = 1'b1;
        tick();
        val      = 8'd100;
        in_value = val;
        tick();
        feed(16, -1);
        check("sat_valid", 32'(out_valid), 32'd1);
        check("sat_sum",   32'(out_sum),   32'd1023);
        check("sat_wraps", 32'(out_wraps), 32'd15);

        // Reset mid-window with a result pending
        out_ready = 1'b0;
        feed(5, 1);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_sum",   32'(out_sum),   32'd0);
        check("midrst_wraps", 32'(out_wraps), 32'd0);
`ifdef WINDOW_SAMPLER_OVERRUN_EN
        check("midrst_overrun", 32'(out_overrun), 32'd0);
`endif
        tick();
        tick();
        reset     = 1'b1;
        out_ready = 1'b1;
        val       = 8'd10;
        in_value  = val;
        tick();                 // enable seen: IDLE -> PRIME
        tick();                 // PRIME captures prev = 10
        feed(15, 1);            // 16 edges after enable seen
        check("postrst_latency_valid", 32'(out_valid), 32'd0);
        feed(1, 1);             // 17th edge
        check("postrst_valid", 32'(out_valid), 32'd1);
        check("postrst_sum",   32'(out_sum),   32'd16);
        check("postrst_wraps", 32'(out_wraps), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
